uart_frame_packer: RTL and testbench

- Write-side front end for the UART video path: assembles bytes from the UART receiver into pixels and generates frame-buffer block-RAM write cycles.
- Generalises the fixed two-byte RGB444, two-buffer scheme to parametrised pixel width, bytes per pixel, resolution and buffer count.
- Adds start-of-frame resync, inter-byte timeout recovery and an explicit display-buffer handoff.
- Sits between uart_rx and the BRAM write port, in the UART clock domain.

---
 rtl/uart_frame_packer.sv | 156 +++++++++++++++
 tb/tb_uart_frame_packer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_packer.sv
// UART byte-to-pixel packer: assembles MSB-first bytes into pixels and issues
// frame-buffer write cycles, rotating through NUM_BUF buffers per completed frame.
module uart_frame_packer #(
    parameter int DATA_W        = 12,
    parameter int BYTES_PER_PIX = 2,
    parameter int IMG_W         = 320,
    parameter int IMG_H         = 240,
    parameter int NUM_BUF       = 2,
    parameter int ADDR_W        = 18,
    parameter int TIMEOUT_CYC   = 4096
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [7:0]        i_byte,
    input  logic              i_byte_valid,
    input  logic              i_sof,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic [1:0]        o_disp_buf,
    output logic              o_frame_done,
    output logic              o_err_timeout,
    output logic              o_busy
);

    localparam int FRAME_PIX = IMG_W * IMG_H;
    localparam int PIX_W     = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
    localparam int TMO_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [PIX_W-1:0]  LAST_PIX   = PIX_W'(FRAME_PIX - 1);
    localparam logic [2:0]        LAST_BYTE  = 3'(BYTES_PER_PIX - 1);
    localparam logic [1:0]        LAST_BUF   = 2'(NUM_BUF - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [ADDR_W-1:0] FRAME_SIZE = ADDR_W'(FRAME_PIX);

    typedef enum logic {IDLE, ASSEMBLE} state_t;

    state_t            state_reg, state_next;
    logic [2:0]        byte_cnt_reg, byte_cnt_next;
    logic [PIX_W-1:0]  pix_idx_reg, pix_idx_next;
    logic [1:0]        wbuf_reg, wbuf_next;
    logic [TMO_W-1:0]  tmo_reg, tmo_next;
    logic              wr_en_reg, wr_en_next;
    logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
    logic [DATA_W-1:0] wr_data_reg, wr_data_next;
    logic [1:0]        disp_buf_reg, disp_buf_next;
    logic              frame_done_reg, frame_done_next;
    logic              err_timeout_reg, err_timeout_next;

    logic [DATA_W-1:0] pixel;
    logic [PIX_W-1:0]  cur_idx;
    logic [2:0]        cur_cnt;

    // Only the low DATA_W-8 bits of byte history can ever reach the pixel,
    // so the shift register is sized to that rather than 8*BYTES_PER_PIX.
    generate
        if (DATA_W > 8) begin : g_wide
            logic [DATA_W-9:0] hist_reg;
            assign pixel = {hist_reg, i_byte};
            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn)
                    hist_reg <= '0;
                else if (i_byte_valid)
                    hist_reg <= pixel[DATA_W-9:0];
            end
        end else begin : g_narrow
            assign pixel = i_byte[DATA_W-1:0];
        end
    endgenerate

    always_comb begin
        state_next       = state_reg;
        byte_cnt_next    = byte_cnt_reg;
        pix_idx_next     = pix_idx_reg;
        wbuf_next        = wbuf_reg;
        tmo_next         = tmo_reg;
        wr_en_next       = 1'b0;
        wr_addr_next     = wr_addr_reg;
        wr_data_next     = wr_data_reg;
        disp_buf_next    = disp_buf_reg;
        frame_done_next  = 1'b0;
        err_timeout_next = 1'b0;
        cur_idx          = i_sof ? '0 : pix_idx_reg;
        cur_cnt          = i_sof ? 3'd0 : byte_cnt_reg;

        if (i_byte_valid) begin
            // A start-of-frame byte is byte 0 of pixel 0 regardless of prior progress.
            tmo_next = '0;
            if (cur_cnt == LAST_BYTE) begin
                state_next    = IDLE;
                byte_cnt_next = 3'd0;
                wr_en_next    = 1'b1;
                wr_addr_next  = ADDR_W'(wbuf_reg) * FRAME_SIZE + ADDR_W'(cur_idx);
                wr_data_next  = pixel;
                if (cur_idx == LAST_PIX) begin
                    frame_done_next = 1'b1;
                    disp_buf_next   = wbuf_reg;
                    wbuf_next       = (wbuf_reg == LAST_BUF) ? 2'd0 : wbuf_reg + 2'd1;
                    pix_idx_next    = '0;
                end else begin
                    pix_idx_next = cur_idx + PIX_W'(1);
                end
            end else begin
                state_next    = ASSEMBLE;
                byte_cnt_next = cur_cnt + 3'd1;
                pix_idx_next  = cur_idx;
            end
        end else if (state_reg == ASSEMBLE && TIMEOUT_CYC != 0) begin
            if (tmo_reg == TMO_LAST) begin
                state_next       = IDLE;
                byte_cnt_next    = 3'd0;
                tmo_next         = '0;
                err_timeout_next = 1'b1;
            end else begin
                tmo_next = tmo_reg + TMO_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg       <= IDLE;
            byte_cnt_reg    <= 3'd0;
            pix_idx_reg     <= '0;
            wbuf_reg        <= 2'd0;
            tmo_reg         <= '0;
            wr_en_reg       <= 1'b0;
            wr_addr_reg     <= '0;
            wr_data_reg     <= '0;
            disp_buf_reg    <= 2'd0;
            frame_done_reg  <= 1'b0;
            err_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            byte_cnt_reg    <= byte_cnt_next;
            pix_idx_reg     <= pix_idx_next;
            wbuf_reg        <= wbuf_next;
            tmo_reg         <= tmo_next;
            wr_en_reg       <= wr_en_next;
            wr_addr_reg     <= wr_addr_next;
            wr_data_reg     <= wr_data_next;
            disp_buf_reg    <= disp_buf_next;
            frame_done_reg  <= frame_done_next;
            err_timeout_reg <= err_timeout_next;
        end
    end

    assign o_wr_en       = wr_en_reg;
    assign o_wr_addr     = wr_addr_reg;
    assign o_wr_data     = wr_data_reg;
    assign o_disp_buf    = disp_buf_reg;
    assign o_frame_done  = frame_done_reg;
    assign o_err_timeout = err_timeout_reg;
    assign o_busy        = (state_reg == ASSEMBLE);

endmodule

// File: tb/tb_uart_frame_packer.sv
// Bench for uart_frame_packer: a 2-byte/12-bit/2-buffer instance and a
// 1-byte/8-bit/3-buffer instance, both 4x2 pixels, checked against a queue-free byte model.
module tb_uart_frame_packer;

    localparam int FP  = 8;
    localparam int TMO = 16;

    logic        clk, rst_n;
    logic [7:0]  a_byte, b_byte;
    logic        a_valid, b_valid, a_sof, b_sof;
    logic        a_wr_en, b_wr_en, a_fd, b_fd, a_err, b_err, a_busy, b_busy;
    logic [4:0]  a_wr_addr, b_wr_addr;
    logic [11:0] a_wr_data;
    logic [7:0]  b_wr_data;
    logic [1:0]  a_disp, b_disp;

    uart_frame_packer #(.DATA_W(12), .BYTES_PER_PIX(2), .IMG_W(4), .IMG_H(2), .NUM_BUF(2),
                        .ADDR_W(5), .TIMEOUT_CYC(TMO)) dut_a (
        .i_clk(clk), .i_rstn(rst_n), .i_byte(a_byte), .i_byte_valid(a_valid), .i_sof(a_sof),
        .o_wr_en(a_wr_en), .o_wr_addr(a_wr_addr), .o_wr_data(a_wr_data), .o_disp_buf(a_disp),
        .o_frame_done(a_fd), .o_err_timeout(a_err), .o_busy(a_busy));

    uart_frame_packer #(.DATA_W(8), .BYTES_PER_PIX(1), .IMG_W(4), .IMG_H(2), .NUM_BUF(3),
                        .ADDR_W(5), .TIMEOUT_CYC(TMO)) dut_b (
        .i_clk(clk), .i_rstn(rst_n), .i_byte(b_byte), .i_byte_valid(b_valid), .i_sof(b_sof),
        .o_wr_en(b_wr_en), .o_wr_addr(b_wr_addr), .o_wr_data(b_wr_data), .o_disp_buf(b_disp),
        .o_frame_done(b_fd), .o_err_timeout(b_err), .o_busy(b_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference model: per-instance configuration and state
    int     c_bpp[2]  = '{2, 1};
    int     c_dw[2]   = '{12, 8};
    int     c_nbuf[2] = '{2, 3};
    int     m_n[2], m_pix[2], m_buf[2], m_idle[2];
    longint m_acc[2];
    logic   e_wr_en[2], e_fd[2], e_err[2], e_busy[2];
    int     e_addr[2], e_data[2], e_disp[2];

    typedef struct {
        logic [7:0] by;
        logic       sof;
        logic       en;
        int         addr;
        int         data;
        logic       fd;
        int         disp;
        logic       busy;
    } vec_t;
    vec_t tbl[16];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_n[d] = 0; m_pix[d] = 0; m_buf[d] = 0; m_idle[d] = 0; m_acc[d] = 0;
            e_wr_en[d] = 0; e_fd[d] = 0; e_err[d] = 0; e_busy[d] = 0;
            e_addr[d] = 0; e_data[d] = 0; e_disp[d] = 0;
        end
    endtask

    task automatic model_step(input int d, input logic [7:0] by, input logic v, input logic s);
        e_wr_en[d] = 0; e_fd[d] = 0; e_err[d] = 0;
        if (v) begin
            if (s) begin
                m_n[d] = 0; m_acc[d] = 0; m_pix[d] = 0;
            end
            m_acc[d]  = (m_acc[d] << 8) | longint'(by);
            m_n[d]    = m_n[d] + 1;
            m_idle[d] = 0;
            if (m_n[d] == c_bpp[d]) begin
                e_wr_en[d] = 1;
                e_addr[d]  = m_buf[d] * FP + m_pix[d];
                e_data[d]  = int'(m_acc[d] & ((64'd1 << c_dw[d]) - 1));
                m_n[d] = 0; m_acc[d] = 0;
                if (m_pix[d] == FP - 1) begin
                    e_fd[d]   = 1;
                    e_disp[d] = m_buf[d];
                    m_buf[d]  = (m_buf[d] + 1) % c_nbuf[d];
                    m_pix[d]  = 0;
                end else begin
                    m_pix[d] = m_pix[d] + 1;
                end
            end
        end else if (m_n[d] > 0 && TMO > 0) begin
            m_idle[d] = m_idle[d] + 1;
            if (m_idle[d] == TMO) begin
                m_n[d] = 0; m_acc[d] = 0; m_idle[d] = 0; e_err[d] = 1;
            end
        end
        e_busy[d] = (m_n[d] > 0);
    endtask

    task automatic check_dut(input int d, input string name);
        logic en, fd, err, busy;
        int addr, data, disp;
        logic ok;
        if (d == 0) begin
            en = a_wr_en; fd = a_fd; err = a_err; busy = a_busy;
            addr = int'(a_wr_addr); data = int'(a_wr_data); disp = int'(a_disp);
        end else begin
            en = b_wr_en; fd = b_fd; err = b_err; busy = b_busy;
            addr = int'(b_wr_addr); data = int'(b_wr_data); disp = int'(b_disp);
        end
        ok = (en == e_wr_en[d]) && (!en || (addr == e_addr[d] && data == e_data[d])) &&
             (fd == e_fd[d]) && (disp == e_disp[d]) && (err == e_err[d]) && (busy == e_busy[d]);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s dut%0d t=%0t: got en=%0d addr=%0d data=%h fd=%0d disp=%0d err=%0d busy=%0d, exp en=%0d addr=%0d data=%h fd=%0d disp=%0d err=%0d busy=%0d",
                     name, d, $time, en, addr, data, fd, disp, err, busy,
                     e_wr_en[d], e_addr[d], e_data[d], e_fd[d], e_disp[d], e_err[d], e_busy[d]);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), exp %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step(input logic [7:0] ab, input logic av, input logic as_,
                        input logic [7:0] bb, input logic bv, input logic bs);
        @(negedge clk);
        a_byte = ab; a_valid = av; a_sof = as_;
        b_byte = bb; b_valid = bv; b_sof = bs;
        model_step(0, ab, av, as_);
        model_step(1, bb, bv, bs);
        @(posedge clk);
        #1;
        check_dut(0, "model_a");
        check_dut(1, "model_b");
    endtask

    task automatic idle_a(input int n);
        for (int k = 0; k < n; k++) step(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic pix_a(input logic [7:0] hi, input logic [7:0] lo, input logic s);
        step(hi, 1'b1, s, 8'h00, 1'b0, 1'b0);
        step(lo, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        int cnt_err, cnt_fd, cnt_wr;
        logic ok;
        logic [7:0] rb;
        int idle_left[2];

        for (int i = 0; i < 16; i++) begin
            tbl[i].by   = (i % 2 == 0) ? 8'h0A : 8'hBC;
            tbl[i].sof  = (i == 0);
            tbl[i].en   = (i % 2 == 1);
            tbl[i].addr = i / 2;
            tbl[i].data = 'hABC;
            tbl[i].fd   = (i == 15);
            tbl[i].disp = 0;
            tbl[i].busy = (i % 2 == 0);
        end

        rst_n = 1'b0;
        a_byte = 0; a_valid = 0; a_sof = 0;
        b_byte = 0; b_valid = 0; b_sof = 0;
        model_reset();
        #23;
        check_dut(0, "reset_a");
        check_dut(1, "reset_b");
        @(negedge clk);
        rst_n = 1'b1;

        // frame 1 from the vector table
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].by, 1'b1, tbl[i].sof, 8'h00, 1'b0, 1'b0);
            ok = (a_wr_en == tbl[i].en) &&
                 (!tbl[i].en || (int'(a_wr_addr) == tbl[i].addr && int'(a_wr_data) == tbl[i].data)) &&
                 (a_fd == tbl[i].fd) && (int'(a_disp) == tbl[i].disp) && (a_busy == tbl[i].busy);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL tbl[%0d]: got en=%0d addr=%0d data=%h fd=%0d disp=%0d busy=%0d, exp en=%0d addr=%0d data=%h fd=%0d disp=%0d busy=%0d",
                         i, a_wr_en, a_wr_addr, a_wr_data, a_fd, a_disp, a_busy,
                         tbl[i].en, tbl[i].addr, tbl[i].data, tbl[i].fd, tbl[i].disp, tbl[i].busy);
            end
        end

        // frame 2 lands in buffer 1, frame 3 wraps to buffer 0
        for (int p = 0; p < 8; p++) pix_a(8'h0A, 8'hBC, 1'b0);
        check_val("f2_last_addr", int'(a_wr_addr), 15);
        check_val("f2_done", int'(a_fd), 1);
        check_val("f2_disp", int'(a_disp), 1);
        pix_a(8'h0A, 8'hBC, 1'b0);
        check_val("f3_first_addr", int'(a_wr_addr), 0);

        // timeout: one byte, then 16 idle cycles
        step(8'h0F, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_val("tmo_busy_start", int'(a_busy), 1);
        cnt_err = 0; cnt_wr = 0;
        for (int k = 0; k < TMO + 2; k++) begin
            idle_a(1);
            cnt_err += int'(a_err);
            cnt_wr  += int'(a_wr_en);
        end
        check_val("tmo_pulses", cnt_err, 1);
        check_val("tmo_no_write", cnt_wr, 0);
        check_val("tmo_busy_end", int'(a_busy), 0);
        pix_a(8'h01, 8'h23, 1'b0);
        check_val("tmo_data", int'(a_wr_data), 'h123);
        check_val("tmo_addr", int'(a_wr_addr), 1);

        // resync: 3 pixels, a partial byte, then a start-of-frame pixel
        cnt_fd = 0;
        for (int p = 0; p < 3; p++) begin
            pix_a(8'($urandom), 8'($urandom), 1'b0);
            cnt_fd += int'(a_fd);
        end
        step(8'h05, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        pix_a(8'h07, 8'h89, 1'b1);
        cnt_fd += int'(a_fd);
        check_val("sof_addr", int'(a_wr_addr), 0);
        check_val("sof_data", int'(a_wr_data), 'h789);
        check_val("sof_no_done", cnt_fd, 0);
        check_val("sof_disp_kept", int'(a_disp), 1);

        // single-byte pixels back to back through three buffers
        cnt_wr = 0;
        for (int i = 0; i < 24; i++) begin
            step(8'h00, 1'b0, 1'b0, 8'($urandom), 1'b1, 1'b0);
            cnt_wr += int'(b_wr_en);
            check_val("b2b_addr", int'(b_wr_addr), i);
            if (i % 8 == 7) begin
                check_val("b2b_done", int'(b_fd), 1);
                check_val("b2b_disp", int'(b_disp), i / 8);
            end
        end
        check_val("b2b_writes", cnt_wr, 24);
        step(8'h00, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0);
        check_val("b2b_wrap_addr", int'(b_wr_addr), 0);

        // byte arriving in the would-be expiry cycle wins
        step(8'h0F, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cnt_err = 0;
        for (int k = 0; k < TMO - 1; k++) begin
            idle_a(1);
            cnt_err += int'(a_err);
        end
        step(8'hED, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cnt_err += int'(a_err);
        check_val("coll_wr", int'(a_wr_en), 1);
        check_val("coll_data", int'(a_wr_data), 'hFED);
        idle_a(1);
        cnt_err += int'(a_err);
        check_val("coll_no_err", cnt_err, 0);

        // sof on the final byte of a frame
        for (int p = 0; p < 5; p++) pix_a(8'h01, 8'h11, 1'b0);
        step(8'h02, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(8'h03, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        check_val("sof_last_no_done", int'(a_fd), 0);
        check_val("sof_last_busy", int'(a_busy), 1);
        step(8'h45, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_val("sof_last_addr", int'(a_wr_addr), 0);
        check_val("sof_last_data", int'(a_wr_data), 'h345);
        for (int i = 0; i < 6; i++) step(8'h00, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b0, 8'h20, 1'b1, 1'b1);
        check_val("b_sof_last_addr", int'(b_wr_addr), 0);
        check_val("b_sof_last_done", int'(b_fd), 0);

        // randomized traffic on both instances
        idle_left[0] = 0; idle_left[1] = 0;
        for (int c = 0; c < 800; c++) begin
            logic va, vb, sa, sb;
            for (int d = 0; d < 2; d++)
                if (idle_left[d] == 0 && $urandom_range(0, 39) == 0)
                    idle_left[d] = $urandom_range(10, 24);
            va = (idle_left[0] == 0) && ($urandom_range(0, 99) < 60);
            vb = (idle_left[1] == 0) && ($urandom_range(0, 99) < 60);
            sa = va && ($urandom_range(0, 29) == 0);
            sb = vb && ($urandom_range(0, 29) == 0);
            rb = 8'($urandom);
            step(8'($urandom), va, sa, rb, vb, sb);
            for (int d = 0; d < 2; d++) if (idle_left[d] > 0) idle_left[d]--;
        end

        // reset mid-pixel (a) and with a write in flight (b)
        step(8'h0A, 1'b1, 1'b1, 8'h66, 1'b1, 1'b0);
        #1;
        a_valid = 0; a_sof = 0; b_valid = 0; b_sof = 0;
        rst_n = 1'b0;
        #1;
        check_val("rst_a_busy", int'(a_busy), 0);
        check_val("rst_b_wr_en", int'(b_wr_en), 0);
        check_val("rst_outs", int'({a_wr_en, a_wr_addr, a_wr_data, a_disp, a_fd, a_err,
                                    b_wr_addr, b_wr_data, b_disp, b_fd, b_err, b_busy}), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(8'h0A, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0);
        check_val("post_rst_b_addr", int'(b_wr_addr), 0);
        check_val("post_rst_b_disp", int'(b_disp), 0);
        step(8'hBC, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_val("post_rst_a_addr", int'(a_wr_addr), 0);
        check_val("post_rst_a_data", int'(a_wr_data), 'hABC);
        check_val("post_rst_a_disp", int'(a_disp), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
